// File: rtl/writeback.sv
// ============================================================================
// writeback: Y86-64 W pipeline register, 15x64 register file, retirement FSM
// Optional: WB_RETIRE_CNT_EN enables the 32-bit retired-instruction counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter int         NREG  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [0:3]  m_stat,
   input  logic [3:0]  M_icode,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   output logic [63:0] d_rvalA,
   output logic [63:0] d_rvalB,
   output logic [0:3]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data,
   output logic        halted,
   output logic        fault,
   output logic [31:0] retired
);

   localparam logic [0:3] STAT_AOK = 4'b1000;
   localparam logic [0:3] STAT_HLT = 4'b0100;
   localparam logic [3:0] ICODE_NOP = 4'h1;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] regs [0:NREG-1];
   logic        hold;
   logic        commit;

   function automatic logic addr_ok(input logic [3:0] a);
      return (a != RNONE) && (int'(a) < NREG);
   endfunction

   // Once stopped, the W register is frozen no matter what pipe_control asks.
   assign hold   = W_stall || (state != S_RUN);
   assign commit = (state == S_RUN) && (W_stat == STAT_AOK);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         W_stat  <= STAT_AOK;
         W_icode <= ICODE_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
      end else if (hold) begin
         W_stat  <= W_stat;
      end else if (W_bubble) begin
         W_stat  <= STAT_AOK;
         W_icode <= ICODE_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
      end else begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

   // The M port is written last so it wins on a shared destination (popq %rsp).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (commit) begin
         if (addr_ok(W_dstE)) regs[W_dstE] <= W_valE;
         if (addr_ok(W_dstM)) regs[W_dstM] <= W_valM;
      end
   end

   assign d_rvalA  = addr_ok(d_srcA)   ? regs[d_srcA]   : '0;
   assign d_rvalB  = addr_ok(d_srcB)   ? regs[d_srcB]   : '0;
   assign dbg_data = addr_ok(dbg_addr) ? regs[dbg_addr] : '0;

   // Any status other than AOK or HLT, including non-one-hot codes, is a fault.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_RUN;
         halted <= 1'b0;
         fault  <= 1'b0;
      end else if (state == S_RUN) begin
         if (W_stat == STAT_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
         end else if (W_stat != STAT_AOK) begin
            state  <= S_FAULT;
            fault  <= 1'b1;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (commit && (W_icode != ICODE_NOP) && !W_stall) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

   assign retired = retire_cnt;
`else
   assign retired = '0;
`endif

endmodule

`default_nettype wire
